smul_seq: RTL

- Sequenced vector-scalar multiply engine for the 16-lane x 16-bit vector unit.
- Replaces a fully parallel 16-multiplier array with LANES_PER_CYCLE shared multipliers.
- The shared multipliers are time-multiplexed across the 16 lanes of a 256-bit vector under a start/busy/done handshake.
- Collects per-lane and aggregate overflow; sits between the vector issue logic and the vector register write port.

---
 rtl/smul_seq_if.sv | 26 ++
 rtl/smul_seq.sv | 103 ++++++++++
 2 files changed

// File: rtl/smul_seq_if.sv
// Issue-side bundle of the sequenced vector-scalar multiplier: request operands
// in, busy/done status and lane results out.
interface smul_seq_if;
  // start is a request that takes effect only at an edge where the engine is in
  // IDLE or DONE; busy=1 means a request made now is dropped (never queued),
  // and done is a one-cycle pulse marking product/lane_ovf/ovf as final.
  logic         start;
  logic [15:0]  scalar;
  logic [255:0] vecin;
  logic         busy;
  logic         done;
  logic [255:0] product;
  logic [15:0]  lane_ovf;
  logic         ovf;
  logic [1:0]   fsm_state;

  modport master (
    output start, scalar, vecin,
    input  busy, done, product, lane_ovf, ovf, fsm_state
  );

  modport slave (
    input  start, scalar, vecin,
    output busy, done, product, lane_ovf, ovf, fsm_state
  );
endinterface

// File: rtl/smul_seq.sv
// 16-lane x 16-bit vector-scalar multiply that time-shares LANES_PER_CYCLE
// multipliers over 16/LANES_PER_CYCLE passes, with per-lane overflow flags.
module smul_seq #(
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    smul_seq_if.slave   bus
);
    localparam int L  = LANES_PER_CYCLE;
    localparam int P  = 16 / L;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pass;
    logic [15:0]   scalar_q;
    logic [255:0]  vec_q;
    logic [255:0]  product_q;
    logic [15:0]   lane_ovf_q;
    logic          ovf_q;
    logic          busy_q;
    logic          done_q;

    logic [3:0]         lane_base;
    logic [3:0]         lane_idx  [L];
    logic [15:0]        lane_opnd [L];
    logic signed [31:0] lane_full [L];
    logic [L-1:0]       lane_ov;

    // Lanes handled this pass; overflow means bits [31:15] are not a pure sign extension.
    always_comb begin
        lane_base = 4'(int'(pass) * L);
        lane_ov   = '0;
        for (int j = 0; j < L; j++) begin
            lane_idx[j]  = lane_base + 4'(j);
            lane_opnd[j] = vec_q[{lane_idx[j], 4'b0000} +: 16];
            lane_full[j] = $signed(scalar_q) * $signed(lane_opnd[j]);
            lane_ov[j]   = !((&lane_full[j][31:15]) || !(|lane_full[j][31:15]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pass       <= '0;
            scalar_q   <= '0;
            vec_q      <= '0;
            product_q  <= '0;
            lane_ovf_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    for (int j = 0; j < L; j++) begin
                        product_q[{lane_idx[j], 4'b0000} +: 16] <= lane_full[j][15:0];
                        lane_ovf_q[lane_idx[j]]                 <= lane_ov[j];
                    end
                    // Results are cleared at acceptance, so accumulating keeps ovf == |lane_ovf.
                    ovf_q <= ovf_q | (|lane_ov);
                    if (pass == PW'(P - 1)) begin
                        state  <= DONE;
                        pass   <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        pass <= pass + PW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept, which gives back-to-back issue without a bubble.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= RUN;
                        pass       <= '0;
                        scalar_q   <= bus.scalar;
                        vec_q      <= bus.vecin;
                        product_q  <= '0;
                        lane_ovf_q <= '0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.lane_ovf  = lane_ovf_q;
    assign bus.ovf       = ovf_q;
    assign bus.fsm_state = state;
endmodule
